// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_RX_MAJORITY_VOTE_EN to decode each bit as a 3-sample majority around mid-bit.
module uart_rx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Par_err,
    output logic                      Stp_err
);

    localparam int unsigned PW  = PRESCALE_WIDTH;
    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned BCW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [PW-1:0]   edge_cnt;
    logic [BCW-1:0]  bit_cnt;
    logic [PW-1:0]   prescale_q;
    logic            par_en_q;
    logic            par_typ_q;
    logic            par_err_flag;
    logic [DW-1:0]   shift_reg;
    logic            samp_mid;

    logic [PW-1:0]   sample_pt;
    logic [PW-1:0]   decide_pt;
    logic [PW-1:0]   last_edge;
    logic            bit_end;
    logic            decide;
    logic            bit_val;

    // Sample point is mid-bit; the decision is taken one cycle later so a third vote is available.
    assign sample_pt = {1'b0, prescale_q[PW-1:1]};
    assign decide_pt = sample_pt + PW'(1);
    assign last_edge = prescale_q - PW'(1);
    assign bit_end   = (edge_cnt == last_edge);
    assign decide    = (edge_cnt == decide_pt);

    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_mid <= 1'b0;
        end else if (edge_cnt == sample_pt) begin
            samp_mid <= RX_IN;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic samp_early;

    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_early <= 1'b0;
        end else if (edge_cnt == sample_pt - PW'(1)) begin
            samp_early <= RX_IN;
        end
    end

    // The third vote is the live line value at the decision count.
    assign bit_val = (samp_early & samp_mid) | (samp_early & RX_IN) | (samp_mid & RX_IN);
`else
    assign bit_val = samp_mid;
`endif

    // Frame FSM with bit/edge counters and registered result pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err_flag <= 1'b0;
            shift_reg    <= '0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Par_err      <= 1'b0;
            Stp_err      <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PW'(1);
            end

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!RX_IN) begin
                        // Detection cycle is edge 0 of the start bit.
                        state        <= START;
                        edge_cnt     <= PW'(1);
                        prescale_q   <= Prescale;
                        par_en_q     <= PAR_EN;
                        par_typ_q    <= PAR_TYP;
                        par_err_flag <= 1'b0;
                    end
                end

                START: begin
                    if (decide && bit_val) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (decide) begin
                        shift_reg <= {bit_val, shift_reg[DW-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_cnt == BCW'(DW - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end

                PARITY: begin
                    if (decide && (bit_val != ((^shift_reg) ^ par_typ_q))) begin
                        par_err_flag <= 1'b1;
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    // Leave half a bit early so a back-to-back start edge is not missed.
                    if (decide) begin
                        state      <= IDLE;
                        edge_cnt   <= '0;
                        Data_Valid <= bit_val & ~par_err_flag;
                        Par_err    <= par_err_flag;
                        Stp_err    <= ~bit_val;
                        if (bit_val && !par_err_flag) begin
                            P_DATA <= shift_reg;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame decode, parity/stop errors, false start, back-to-back, reset, glitch.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_err;
    logic       Stp_err;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_err    (Par_err),
        .Stp_err    (Stp_err)
    );

    always #5 CLK = ~CLK;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h01;
`endif

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every cycle with any pulse high is logged, so a wide pulse shows up as extra events.
    always @(negedge CLK) begin
        if (Data_Valid || Par_err || Stp_err) begin
            evq.push_back('{cyc, Data_Valid, Par_err, Stp_err, P_DATA});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_level(input logic v, input int n);
        RX_IN = v;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                              input logic pbit, input logic stop_bit, input logic scramble,
                              output int t0);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        t0       = cyc;
        drive_level(1'b0, p);
        if (scramble) begin
            Prescale = 6'd16;
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
        end
        for (int k = 0; k < 8; k++) drive_level(d[k], p);
        if (pen) drive_level(pbit, p);
        drive_level(stop_bit, p);
        RX_IN    = 1'b1;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
    endtask

    task automatic expect_frame(input string tag, input int t0, input int rel, input logic dv,
                                input logic pe, input logic se, input logic [7:0] pd);
        check({tag, "_count"}, 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check({tag, "_cycle"}, 32'(evq[0].cyc - t0), 32'(rel));
            check({tag, "_dv"}, 32'(evq[0].dv), 32'(dv));
            check({tag, "_par"}, 32'(evq[0].pe), 32'(pe));
            check({tag, "_stp"}, 32'(evq[0].se), 32'(se));
            check({tag, "_pdata"}, 32'(evq[0].pd), 32'(pd));
        end
        evq.delete();
    endtask

    initial begin
        int t0;
        int t1;

        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_pdata", 32'(P_DATA), 32'h0);
        check("reset_dv", 32'(Data_Valid), 32'h0);
        check("reset_par", 32'(Par_err), 32'h0);
        check("reset_stp", 32'(Stp_err), 32'h0);
        RST = 1'b0;
        drive_level(1'b1, 4);

        // P=8, no parity: stop at 72, decision at 77, visible at 78.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        drive_level(1'b1, 24);
        expect_frame("p8_a5", t0, 78, 1'b1, 1'b0, 1'b0, 8'hA5);

        // P=16 even parity, 0x3C has four ones so bit 1 is wrong; visible at 160+9+1.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t0);
        drive_level(1'b1, 24);
        expect_frame("p16_parerr", t0, 170, 1'b0, 1'b1, 1'b0, 8'hA5);
        check("p16_parerr_hold", 32'(P_DATA), 32'hA5);

        // P=16 odd parity, correct bit 1.
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, t0);
        drive_level(1'b1, 24);
        expect_frame("p16_oddok", t0, 170, 1'b1, 1'b0, 1'b0, 8'h3C);

        // P=8 stop bit 0: error pulse at 78; the low stop tail is rejected as a false start.
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        drive_level(1'b1, 24);
        expect_frame("p8_stperr", t0, 78, 1'b0, 1'b0, 1'b1, 8'h3C);

        // P=8 even parity, 0x07 needs parity 1; sending 0 with stop 0 raises both errors at 86.
        send_frame(8'h07, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        drive_level(1'b1, 24);
        expect_frame("p8_both", t0, 86, 1'b0, 1'b1, 1'b1, 8'h3C);

        // False start: two low cycles then idle.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_level(1'b0, 2);
        drive_level(1'b1, 20);
        check("false_start_quiet", 32'(evq.size()), 32'd0);
        evq.delete();

        // Valid 0x81 with Prescale/parity inputs disturbed mid-frame.
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
        drive_level(1'b1, 24);
        expect_frame("p8_81_latched", t0, 78, 1'b1, 1'b0, 1'b0, 8'h81);

        // Back-to-back at P=32: pulses at 288+17+1 and 320 later.
        send_frame(8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        send_frame(8'hFE, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t1);
        drive_level(1'b1, 24);
        check("b2b_count", 32'(evq.size()), 32'd2);
        check("b2b_gap", 32'(t1 - t0), 32'd320);
        if (evq.size() >= 2) begin
            check("b2b_first_cycle", 32'(evq[0].cyc - t0), 32'd306);
            check("b2b_first_pdata", 32'(evq[0].pd), 32'h01);
            check("b2b_first_dv", 32'(evq[0].dv), 32'd1);
            check("b2b_second_cycle", 32'(evq[1].cyc - t0), 32'd626);
            check("b2b_second_pdata", 32'(evq[1].pd), 32'hFE);
            check("b2b_second_dv", 32'(evq[1].dv), 32'd1);
        end
        evq.delete();

        // Reset at cycle 40 of a 0xFF frame; the remaining line stays high so nothing restarts.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_level(1'b0, 8);
        for (int k = 0; k < 4; k++) drive_level(1'b1, 8);
        RST = 1'b1;
        drive_level(1'b1, 1);
        RST = 1'b0;
        check("midreset_pdata", 32'(P_DATA), 32'h0);
        check("midreset_dv", 32'(Data_Valid), 32'h0);
        check("midreset_errs", 32'({Par_err, Stp_err}), 32'h0);
        drive_level(1'b1, 7 + 24 + 8 + 24);
        check("midreset_quiet", 32'(evq.size()), 32'd0);
        evq.delete();

        // One-cycle high glitch at the sample point of data bit 0 (cycle 12) in an all-zero frame.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        t0 = cyc;
        drive_level(1'b0, 8);
        drive_level(1'b0, 4);
        drive_level(1'b1, 1);
        drive_level(1'b0, 3);
        drive_level(1'b0, 56);
        drive_level(1'b1, 8);
        drive_level(1'b1, 24);
        expect_frame("glitch", t0, 78, 1'b1, 1'b0, 1'b0, GLITCH_EXP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
